// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO controller.
// Holds the status-flag bundle and the occupancy-to-flag decoder.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADD_WIDTH  = 4;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    localparam fifo_status_t RESET_STATUS = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    function automatic fifo_status_t decode_status(
        input int cnt,
        input int depth,
        input int af,
        input int ae
    );
        fifo_status_t s;
        s.full         = (cnt == depth);
        s.empty        = (cnt == 0);
        s.almost_full  = (cnt >= af);
        s.almost_empty = (cnt <= ae);
        return s;
    endfunction

endpackage

// File: rtl/RegFile.sv
// Register-file storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module RegFile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADD_WIDTH-1:0]  w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADD_WIDTH-1:0]  r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** ADD_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller around one RegFile used as a ring buffer.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
    parameter int AF_LEVEL   = 2 ** ADD_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADD_WIDTH:0]    count
);

    localparam int DEPTH = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] ONE = 1;

    logic [ADD_WIDTH:0]    wr_ptr;
    logic [ADD_WIDTH:0]    rd_ptr;
    logic [ADD_WIDTH:0]    count_q;
    logic [ADD_WIDTH:0]    count_d;
    fifo_status_t          status_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] r_data;

    // Acceptance is gated by registered flags only.
    assign wr_acc = wr_en & ~status_q.full;
    assign rd_acc = rd_en & ~status_q.empty;

    RegFile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .w_en   (wr_acc),
        .w_addr (wr_ptr[ADD_WIDTH-1:0]),
        .w_data (wr_data),
        .r_addr (rd_ptr[ADD_WIDTH-1:0]),
        .r_data (r_data)
    );

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            (wr_acc & ~rd_acc): count_d = count_q + ONE;
            (rd_acc & ~wr_acc): count_d = count_q - ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            status_q <= RESET_STATUS;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ONE;
                rd_data <= r_data;
            end
            rd_valid <= rd_acc;
            count_q  <= count_d;
            // Flags are registered alongside the count they describe.
            status_q <= decode_status(int'(count_d), DEPTH,
                                      AF_LEVEL, AE_LEVEL);
        end
    end

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;

`ifdef FIFO_ERR_FLAGS_EN
    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & status_q.full) |
                         (overflow & ~err_clr);
            underflow <= (rd_en & status_q.empty) |
                         (underflow & ~err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (8-bit, depth 16, AF 14, AE 2).
// Directed table, corner sequences and random traffic against a queue model.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DATA_WIDTH (8),
        .ADD_WIDTH  (4),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == 16));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`endif
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        int sz;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        sz = q.size();
        m_valid = 1'b0;
        if (r && sz > 0) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end
        if (w && sz < 16) q.push_back(d);
        m_ovf = (w && sz == 16) || (m_ovf && !c);
        m_udf = (r && sz == 0) || (m_udf && !c);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_model();
    endtask

    // Reset asserted with traffic still requested: nothing may land.
    task automatic do_reset(input logic burst);
        wr_en   = burst;
        wr_data = 8'h5A;
        rd_en   = burst;
        rst     = 1'b1;
        #2;
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check_model();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        check_model();
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'hB2, 1'b1, 1, 1'b1, 8'hA1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hB2};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hB2};
        tbl[4] = '{1'b1, 8'hC3, 1'b1, 1, 1'b0, 8'hB2};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'hB2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hC3};
        tbl[7] = '{1'b1, 8'hD4, 1'b0, 1, 1'b0, 8'hC3};

        do_reset(1'b0);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("tbl%0d_count", i), 32'(count),
                32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid),
                32'(tbl[i].vld));
            chk($sformatf("tbl%0d_data", i), 32'(rd_data),
                32'(tbl[i].dat));
        end

        // Reset mid-burst.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b1, 1'b0);
        do_reset(1'b1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);

        // Fill to full, then one dropped write.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 12) chk("af_at13", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at14", 32'(almost_full), 32'd1);
            if (i == 14) chk("full_at15", 32'(full), 32'd0);
        end
        chk("full_at16", 32'(full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_set", 32'(overflow), 32'd1);
`endif

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d", i), 32'(rd_data), 32'(i));
            chk($sformatf("drain%0d_v", i), 32'(rd_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("extra_rd_v", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_set", 32'(underflow), 32'd1);
`endif

        // Wrap: pointers start at 16 and cross both wrap points.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++)
                step(1'b1, 8'(8'h40 + k * 10 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                chk($sformatf("wrap%0d_%0d", k, i), 32'(rd_data),
                    32'(8'h40 + k * 10 + i));
            end
        end
        chk("wrap_count", 32'(count), 32'd0);

        // Simultaneous at full: read wins, write dropped.
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("sim_full_cnt", 32'(count), 32'd15);
        chk("sim_full_dat", 32'(rd_data), 32'h80);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("sim_drain%0d", i), 32'(rd_data),
                32'(8'h81 + i));
        end

        // Simultaneous at empty: write wins, no fall-through.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("sim_empty_cnt", 32'(count), 32'd1);
        chk("sim_empty_v", 32'(rd_valid), 32'd0);

        // Simultaneous at count 5.
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(8'h78 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("sim5_cnt", 32'(count), 32'd5);
        chk("sim5_dat", 32'(rd_data), 32'h77);

`ifdef FIFO_ERR_FLAGS_EN
        for (int i = 0; i < 11; i++)
            step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_again", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 8'hAB, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
`endif

        // Random traffic with a shifting write/read bias.
        do_reset(1'b0);
        for (int p = 0; p < 8; p++) begin
            int wp;
            wp = 20 + (p * 10) % 70;
            for (int i = 0; i < 400; i++) begin
                step(1'($urandom_range(99) < wp),
                     8'($urandom),
                     1'($urandom_range(99) < 50),
                     1'($urandom_range(99) < 5));
            end
        end

        do_reset(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
